// File: rtl/pwl_pkg.sv
// Shared constants and helpers for the piecewise-linear activation unit:
// Q-format derivation, mode encoding and the per-mode saturation/clamp levels.
package pwl_pkg;

  localparam int INT_BITS = 3;

  typedef enum logic {
    MODE_TANH    = 1'b0,
    MODE_SIGMOID = 1'b1
  } pwl_mode_e;

  // Fraction bits for a WL-bit word with 1 sign and INT_BITS integer bits.
  function automatic int pwl_frac(input int wl);
    return wl - INT_BITS - 1;
  endfunction

  // Fixed-point representation of +1.0.
  function automatic longint pwl_one(input int frac);
    longint one;
    one = 64'sd1 <<< frac;
    return one;
  endfunction

  // Upper (hi=1) or lower (hi=0) output limit for a mode; doubles as the
  // value forced when the input lies outside the table range.
  function automatic longint pwl_limit(input pwl_mode_e mode, input logic hi,
                                       input int frac);
    longint lim;
    if (hi) begin
      lim = pwl_one(frac);
    end else if (mode == MODE_TANH) begin
      lim = -pwl_one(frac);
    end else begin
      lim = 64'sd0;
    end
    return lim;
  endfunction

endpackage

// File: rtl/pwl_act_unit_if.sv
// Sample stream, result stream and coefficient-write port of pwl_act_unit.
interface pwl_act_unit_if #(
  parameter int WL        = 18,
  parameter int NSEG_LOG2 = 6
);

  // Valid-only streams, no ready: in_valid marks a sample taken that cycle,
  // out_valid marks a result presented that cycle; coef_we is a one-cycle
  // write strobe that is always accepted.
  logic                 in_valid;
  logic [WL-1:0]        in_data;
  logic                 in_mode;
  logic                 out_valid;
  logic [WL-1:0]        out_data;
  logic                 coef_we;
  logic [NSEG_LOG2:0]   coef_addr;
  logic [WL-1:0]        coef_a;
  logic [WL-1:0]        coef_b;

  modport master (
    output in_valid, in_data, in_mode, coef_we, coef_addr, coef_a, coef_b,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, coef_we, coef_addr, coef_a, coef_b,
    output out_valid, out_data
  );

endinterface

// File: rtl/pwl_coef_ram.sv
// Coefficient table: one write port, one registered read port. A read and a
// write to the same address in the same cycle return the previous contents.
module pwl_coef_ram #(
  parameter int AW = 7,
  parameter int DW = 36
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // No reset: table contents must survive a pipeline reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pwl_act_unit.sv
// Four-stage piecewise-linear activation y = a[seg]*x + b[seg] with
// per-sample tanh/sigmoid selection and a runtime-loadable coefficient table.
module pwl_act_unit
  import pwl_pkg::*;
#(
  parameter int WL        = 18,
  parameter int NSEG_LOG2 = 6
) (
  input logic           clk,
  input logic           rst,
  pwl_act_unit_if.slave bus
);

  localparam int FRAC = pwl_frac(WL);
  localparam int PW   = 2 * WL;
  localparam int SW   = PW + 2;
  localparam int AW   = NSEG_LOG2 + 1;
  localparam logic signed [WL-1:0] FOUR  = WL'(1) << (FRAC + 2);
  localparam logic signed [WL-1:0] MFOUR = -FOUR;

  // Stage 1: range check and segment index
  logic signed [WL-1:0]   x_d;
  logic [WL-1:0]          off_d;
  logic [NSEG_LOG2-1:0]   seg_d;
  logic                   sat_hi_d;
  logic                   sat_lo_d;

  always_comb begin
    x_d      = $signed(bus.in_data);
    off_d    = x_d + FOUR;
    // Top NSEG_LOG2 bits of the [0,8) offset select one of the segments over [-4,4).
    seg_d    = NSEG_LOG2'(off_d >> (FRAC + 3 - NSEG_LOG2));
    sat_hi_d = (x_d >= FOUR);
    sat_lo_d = (x_d < MFOUR);
  end

  logic                   v1_q, v2_q, v3_q;
  logic signed [WL-1:0]   x1_q, x2_q;
  pwl_mode_e              m1_q, m2_q, m3_q;
  logic [NSEG_LOG2-1:0]   seg1_q;
  logic                   hi1_q, hi2_q, hi3_q;
  logic                   lo1_q, lo2_q, lo3_q;
  logic signed [PW-1:0]   prod3_q;
  logic signed [WL-1:0]   b3_q;
  logic                   out_valid_q;
  logic signed [WL-1:0]   out_data_q;

  // Stage 2: table read; read data lines up with the stage-2 registers
  logic [PW-1:0]          rd_data;
  logic signed [WL-1:0]   a2;
  logic signed [WL-1:0]   b2;
  logic signed [PW-1:0]   prod_d;

  pwl_coef_ram #(
    .AW (AW),
    .DW (PW)
  ) u_coef_ram (
    .clk_i   (clk),
    .we_i    (bus.coef_we),
    .waddr_i (bus.coef_addr),
    .wdata_i ({bus.coef_a, bus.coef_b}),
    .raddr_i ({m1_q, seg1_q}),
    .rdata_o (rd_data)
  );

  assign a2     = $signed(rd_data[PW-1:WL]);
  assign b2     = $signed(rd_data[WL-1:0]);
  assign prod_d = $signed({{WL{a2[WL-1]}}, a2}) * $signed({{WL{x2_q[WL-1]}}, x2_q});

  // Stage 4: rescale, round half-up, clamp / saturate
  logic signed [SW-1:0]   p_ext;
  logic signed [SW-1:0]   sum_d;
  logic signed [SW-1:0]   hi_lim;
  logic signed [SW-1:0]   lo_lim;
  logic signed [WL-1:0]   y_d;

  always_comb begin
    p_ext  = $signed({{2{prod3_q[PW-1]}}, prod3_q});
    sum_d  = (p_ext >>> FRAC)
           + $signed({{(SW-WL){b3_q[WL-1]}}, b3_q})
           + $signed({{(SW-1){1'b0}}, prod3_q[FRAC-1]});
    hi_lim = SW'(pwl_limit(m3_q, 1'b1, FRAC));
    lo_lim = SW'(pwl_limit(m3_q, 1'b0, FRAC));
    y_d    = WL'(sum_d);
    if (hi3_q) begin
      y_d = WL'(hi_lim);
    end else if (lo3_q) begin
      y_d = WL'(lo_lim);
    end else if (sum_d > hi_lim) begin
      y_d = WL'(hi_lim);
    end else if (sum_d < lo_lim) begin
      y_d = WL'(lo_lim);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      x1_q        <= '0;
      x2_q        <= '0;
      m1_q        <= MODE_TANH;
      m2_q        <= MODE_TANH;
      m3_q        <= MODE_TANH;
      seg1_q      <= '0;
      hi1_q       <= 1'b0;
      hi2_q       <= 1'b0;
      hi3_q       <= 1'b0;
      lo1_q       <= 1'b0;
      lo2_q       <= 1'b0;
      lo3_q       <= 1'b0;
      prod3_q     <= '0;
      b3_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      v1_q        <= bus.in_valid;
      x1_q        <= x_d;
      m1_q        <= pwl_mode_e'(bus.in_mode);
      seg1_q      <= seg_d;
      hi1_q       <= sat_hi_d;
      lo1_q       <= sat_lo_d;

      v2_q        <= v1_q;
      x2_q        <= x1_q;
      m2_q        <= m1_q;
      hi2_q       <= hi1_q;
      lo2_q       <= lo1_q;

      v3_q        <= v2_q;
      prod3_q     <= prod_d;
      b3_q        <= b2;
      m3_q        <= m2_q;
      hi3_q       <= hi2_q;
      lo3_q       <= lo2_q;

      out_valid_q <= v3_q;
      out_data_q  <= y_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_pwl_act_unit.sv
// Directed and streamed checks of pwl_act_unit against a fixed-point model
// fed with the same coefficient table the bench loads into the design.
module tb_pwl_act_unit;

  localparam int WL        = 18;
  localparam int NSEG_LOG2 = 6;
  localparam int FRAC      = 14;
  localparam int ONE       = 16384;
  localparam int NSEG      = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwl_act_unit_if #(.WL(WL), .NSEG_LOG2(NSEG_LOG2)) bus ();

  pwl_act_unit #(.WL(WL), .NSEG_LOG2(NSEG_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- check / scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp,
                          input int tol = 0);
    longint diff;
    checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  logic [WL-1:0] exp_q[$];
  int            tol_q[$];
  string         tag_q[$];
  logic [3:0]    hist_q;
  bit            mon_en = 1'b0;

  int ta [2*NSEG];
  int tbv[2*NSEG];

  always @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= {hist_q[2:0], bus.in_valid};
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check_eq("valid_delay4", longint'(bus.out_valid), longint'(hist_q[3]));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 0, 1);
        end else begin
          logic [WL-1:0] e;
          int t;
          string tg;
          e  = exp_q.pop_front();
          t  = tol_q.pop_front();
          tg = tag_q.pop_front();
          check_eq(tg, longint'($signed(bus.out_data)), longint'($signed(e)), t);
        end
      end
    end
  end

  // ---------------- model ----------------
  function automatic int qround(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic real act_f(input bit m, input real x);
    return m ? (1.0 / (1.0 + $exp(-x))) : $tanh(x);
  endfunction

  function automatic int model(input int x, input bit m);
    longint p, s, lo;
    int idx;
    if (x >= 65536) return ONE;
    if (x < -65536) return m ? 0 : -ONE;
    idx = (m ? NSEG : 0) + ((x + 65536) >>> 11);
    p   = longint'(ta[idx]) * longint'(x);
    s   = (p >>> FRAC) + longint'(tbv[idx]) + ((p >>> (FRAC - 1)) & 64'sd1);
    lo  = m ? 0 : -ONE;
    if (s > ONE) s = ONE;
    if (s < lo)  s = lo;
    return int'(s);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input bit v, input int x, input bit m, input bit we,
                       input int addr, input int a, input int b);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = WL'(x);
    bus.in_mode   = m;
    bus.coef_we   = we;
    bus.coef_addr = (NSEG_LOG2+1)'(addr);
    bus.coef_a    = WL'(a);
    bus.coef_b    = WL'(b);
  endtask

  task automatic send(input int x, input bit m, input int exp, input int tol,
                      input string tag);
    drive(1'b1, x, m, 1'b0, 0, 0, 0);
    exp_q.push_back(WL'(exp));
    tol_q.push_back(tol);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit m;
    int x;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_a    = '0;
    bus.coef_b    = '0;

    repeat (3) @(negedge clk);
    check_eq("reset_out_valid", longint'(bus.out_valid), 0);
    check_eq("reset_out_data", longint'($signed(bus.out_data)), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < NSEG; i++) begin
      for (int mm = 0; mm < 2; mm++) begin
        real x0, a, b;
        x0 = -4.0 + real'(i) / 8.0;
        a  = (act_f(mm[0], x0 + 0.125) - act_f(mm[0], x0)) * 8.0;
        b  = act_f(mm[0], x0) - a * x0;
        ta[mm*NSEG + i]  = qround(a * ONE);
        tbv[mm*NSEG + i] = qround(b * ONE);
      end
    end
    for (int i = 0; i < 2*NSEG; i++) drive(1'b0, 0, 1'b0, 1'b1, i, ta[i], tbv[i]);
    idle(2);

    // tanh: zero point and saturation / range edges
    send(0, 1'b0, 0, 2, "tanh_zero");
    idle(5);
    send(-81920, 1'b0, -16384, 0, "tanh_sat_lo");
    send(122880, 1'b0, 16384, 0, "tanh_sat_hi");
    send(65536,  1'b0, 16384, 0, "tanh_at_plus4");
    send(-65536, 1'b0, model(-65536, 1'b0), 0, "tanh_minus4_seg0");
    send(65535,  1'b0, model(65535, 1'b0), 0, "tanh_top_seg");
    // sigmoid
    send(73728,  1'b1, 16384, 0, "sig_sat_hi");
    send(-98304, 1'b1, 0, 0, "sig_sat_lo");
    send(0,      1'b1, 8192, 2, "sig_zero");
    send(-65536, 1'b1, model(-65536, 1'b1), 0, "sig_minus4_seg0");
    idle(6);

    // interleaved stream with bubbles
    m = 1'b0;
    for (int i = 0; i < 1000; ) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 0, m, 1'b0, 0, 0, 0);
      end else begin
        if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 262143)) - 131072;
        else                           x = int'($urandom_range(0, 131071)) - 65536;
        send(x, m, model(x, m), 0, "stream");
        i++;
      end
      m = ~m;
    end
    idle(8);
    check_eq("stream_drain", exp_q.size(), 0);

    // write to seg 32 (tanh) in the cycle the sample reads it
    send(0, 1'b0, model(0, 1'b0), 0, "coll_old");
    drive(1'b0, 0, 1'b0, 1'b1, 32, 0, 1000);
    ta[32]  = 0;
    tbv[32] = 1000;
    send(0,    1'b0, 1000, 0, "coll_new");
    send(2000, 1'b0, 1000, 0, "coll_new_2");
    send(-2000, 1'b0, model(-2000, 1'b0), 0, "coll_other_seg");
    idle(8);
    check_eq("coll_drain", exp_q.size(), 0);

    // asynchronous reset with samples in flight
    drive(1'b1, -81920, 1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 0, 1'b1, 1'b0, 0, 0, 0);
    drive(1'b1, 73728, 1'b1, 1'b0, 0, 0, 0);
    idle(1);
    @(posedge clk);
    #2;
    check_eq("pre_rst_out_valid", longint'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", longint'(bus.out_valid), 0);
    check_eq("rst_async_data", longint'($signed(bus.out_data)), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    send(0, 1'b0, 1000, 0, "post_rst_table");
    send(0, 1'b1, 8192, 2, "post_rst_sig");
    idle(8);
    check_eq("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwl_act_unit.md
Name: pwl_act_unit

Overview:
Parametrised, fully pipelined piecewise-linear activation unit: y = a[seg]*x + b[seg]. Supports tanh and sigmoid modes, sized by word width and segment count. Coefficients live in a runtime-loadable table, not hard-coded. Sits after the LSTM/CNN MAC accumulators in the modulation-recognition datapath and accepts one sample per clock.

Parameters:
WL, 18, data/coefficient word length; signed two's complement, 1 sign, 3 integer, FRAC=WL-4 fraction bits
NSEG_LOG2, 6, log2 of segments per mode; segments uniformly cover [-4,4)
LAT, 4, fixed input-to-output latency in cycles; informative only, not overridable

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  sample qualifier
in_data  in  WL  x, Q3.FRAC
in_mode  in  1  0=tanh, 1=sigmoid; per sample
out_valid  out  1  result qualifier
out_data  out  WL  y, Q3.FRAC
coef_we  in  1  coefficient write strobe
coef_addr  in  NSEG_LOG2+1  {mode, seg}
coef_a  in  WL  slope, Q3.FRAC
coef_b  in  WL  intercept, Q3.FRAC

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, all pipeline valids cleared; in-flight samples dropped. Coefficient table contents are unaffected by reset.
- No backpressure. One sample is accepted per cycle when in_valid=1. out_valid follows in_valid exactly LAT=4 cycles later; bubbles are preserved.
- S1 (register input):
  - sat_hi when x >= +4.0; sat_lo when x < -4.0.
  - seg = bits of (x + 4.0) from [FRAC+2] down to [FRAC+3-NSEG_LOG2], i.e. the top NSEG_LOG2 bits of the offset value.
  - Register x, mode, seg, sat flags and valid.
- S2: synchronous table read at {mode, seg}; x, mode and sat flags delayed to match.
- S3: signed product a*x, full 2WL bits, registered.
- S4:
  - sum = (product >>> FRAC) + b.
  - Round half-up using product bit FRAC-1.
  - Clamp tanh results to [-1.0, +1.0] (-2^FRAC .. 2^FRAC) and sigmoid results to [0, +1.0].
  - Saturation overrides the table: tanh sat_hi -> +2^FRAC, sat_lo -> -2^FRAC; sigmoid sat_hi -> +2^FRAC, sat_lo -> 0.
- Coefficient writes:
  - Accepted on any cycle and take effect the next cycle.
  - A write and an S2 read to the same address in the same cycle: the read returns the OLD value.
  - Writes never stall or corrupt in-flight samples that use other addresses.
- Mode is carried per sample, so interleaved tanh/sigmoid streams are legal.
- x exactly -4.0 -> seg 0, not saturated. x = +4.0 - 1 LSB -> seg NSEG-1.

Decomposition:
- Package pwl_pkg: FRAC derivation, ONE = 2^FRAC constant, mode encoding (MODE_TANH=0, MODE_SIGMOID=1), saturation constants per mode.
- Sub-module pwl_coef_ram: 2*NSEG x 2WL simple dual-port, one write port and one registered read port, read-old-on-collision. The unit instantiates one pwl_coef_ram; the multiplier and adder are inferred in the top level.

Test Plan:
- Load the tanh table (mode 0), then x=0, mode=0 -> out_data within ±2 LSB of 0, out_valid exactly 4 cycles after in_valid.
- Tanh saturation: x=-5.0 (-81920), mode=0 -> -16384; x=+7.5 (122880) -> +16384.
- Sigmoid, table loaded: x=+4.5 -> 16384; x=-6.0 -> 0; x=0 -> 8192 ±2 LSB.
- Streaming: 1000 random x, alternating mode every cycle, with random in_valid gaps -> every output matches the golden model bit-exactly (same rounding/clamp); out_valid pattern equals in_valid delayed by 4.
- Collision: write seg k with a=0, b=1000 in the same cycle a sample of seg k reaches S2 -> that sample uses the old coefficients; the next sample of seg k yields 1000.
- Reset mid-stream: assert rst asynchronously with 3 samples in flight -> out_valid=0 immediately and no stale outputs after release; the table still holds the written coefficients.
